ccff_stream_loader: RTL and testbench



---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_word_serializer.sv | 66 ++++++
 rtl/ccff_stream_loader.sv | 129 ++++++++++++
 tb/tb_ccff_stream_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared state type and CRC helpers for the configuration chain loader
package ccff_loader_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - word shift register with one-entry skid buffer and s_ready generation
module ccff_word_serializer #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              active,
  input  logic              shift,
  input  logic [LEN_W-1:0]  need,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              msb,
  output logic              has_bits
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int BUF_W = $clog2(2 * WORD_W + 1);

  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] skid;
  logic [CNT_W-1:0]  scnt;
  logic              skid_full;
  logic [BUF_W-1:0]  buffered;
  logic              accept;
  logic              drain;

  // Stop accepting once the bits already held cover what is left of the load.
  assign buffered = BUF_W'(scnt) + (skid_full ? BUF_W'(WORD_W) : BUF_W'(0));
  assign s_ready  = active && !skid_full && (32'(buffered) < 32'(need));
  assign accept   = s_valid && s_ready;
  assign drain    = (scnt == '0) || (shift && (scnt == CNT_W'(1)));
  assign msb      = sreg[WORD_W-1];
  assign has_bits = (scnt != '0);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      sreg      <= '0;
      skid      <= '0;
      scnt      <= '0;
      skid_full <= 1'b0;
    end else begin
      if (shift) begin
        sreg <= sreg << 1;
        scnt <= scnt - CNT_W'(1);
      end
      // Refill on the same edge the last bit leaves so back-to-back words do not bubble.
      if (drain) begin
        if (skid_full) begin
          sreg      <= skid;
          scnt      <= CNT_W'(WORD_W);
          skid_full <= 1'b0;
        end else if (accept) begin
          sreg <= s_data;
          scnt <= CNT_W'(WORD_W);
        end
      end else if (accept) begin
        skid      <= s_data;
        skid_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_stream_loader.sv
// rtl/ccff_stream_loader.sv - configuration chain loader: FSM, bit budget, isolation hold
// Optional tail readback signature enabled by CCFF_READBACK_CRC_EN.
module ccff_stream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int LEN_W     = 20,
  parameter int ISOL_HOLD = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_N,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              IO_ISOL_N,
`ifdef CCFF_READBACK_CRC_EN
  output logic [15:0]       tail_crc,
`endif
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HOLD_W = (ISOL_HOLD > 1) ? $clog2(ISOL_HOLD) : 1;

  state_t            state;
  state_t            state_d;
  logic [LEN_W-1:0]  remaining;
  logic [HOLD_W-1:0] hold_cnt;
  logic              shift;
  logic              has_bits;
  logic              msb;
  logic              hold_last;
  logic              start_ok;
  logic              abort_ok;
  logic              flush;

  assign start_ok  = (state == IDLE) && cfg_start && (cfg_len != '0);
  assign abort_ok  = (state != IDLE) && cfg_abort;
  // Abort wins over a final bit arriving on the same edge.
  assign shift     = (state == SHIFT) && !cfg_abort && has_bits && (remaining != '0);
  assign hold_last = (hold_cnt == HOLD_W'(ISOL_HOLD - 1));
  assign flush     = (state != SHIFT) || cfg_abort;
  assign busy      = (state != IDLE);

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .LEN_W  (LEN_W)
  ) u_ser (
    .clk      (prog_clk),
    .resetn   (pReset_N),
    .flush    (flush),
    .active   (state == SHIFT),
    .shift    (shift),
    .need     (remaining),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .msb      (msb),
    .has_bits (has_bits)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start_ok) state_d = SHIFT;
      SHIFT:   if (cfg_abort) state_d = IDLE;
               else if (shift && (remaining == LEN_W'(1))) state_d = HOLD;
      HOLD:    if (cfg_abort || hold_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_N) begin
      state         <= IDLE;
      remaining     <= '0;
      hold_cnt      <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      IO_ISOL_N     <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_d;
      ccff_shift_en <= shift;
      hold_cnt      <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      if (shift) begin
        ccff_head <= msb;
        remaining <= remaining - LEN_W'(1);
      end
      if (start_ok) begin
        remaining <= cfg_len;
        done      <= 1'b0;
        err       <= 1'b0;
        IO_ISOL_N <= 1'b0;
      end else if ((state == IDLE) && cfg_start) begin
        err <= 1'b1;
      end
      if (abort_ok) begin
        err  <= 1'b1;
        done <= 1'b0;
      end else if ((state == HOLD) && hold_last) begin
        done      <= 1'b1;
        IO_ISOL_N <= 1'b1;
      end
    end
  end

`ifdef CCFF_READBACK_CRC_EN
  always_ff @(posedge prog_clk) begin
    if (!pReset_N || start_ok) begin
      tail_crc <= CRC16_INIT;
    end else if (ccff_shift_en) begin
      tail_crc <= crc16_step(tail_crc, ccff_tail);
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_stream_loader.sv
// tb/tb_ccff_stream_loader.sv - directed self-checking bench for ccff_stream_loader
module tb_ccff_stream_loader;

  logic        prog_clk = 1'b0;
  logic        pReset_N;
  logic        cfg_start;
  logic [19:0] cfg_len;
  logic        cfg_abort;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        ccff_head;
  logic        ccff_shift_en;
  logic        ccff_tail;
  logic        IO_ISOL_N;
  logic        busy;
  logic        done;
  logic        err;
`ifdef CCFF_READBACK_CRC_EN
  logic [15:0] tail_crc;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] words [0:3];
  logic        got_bits [0:127];
  int          n_en, accepted, extra_ready, first_acc, first_en, last_en, isol_rise;
  bit          stall_seen, head_hold_ok, finished;

  ccff_stream_loader dut (
    .prog_clk      (prog_clk),
    .pReset_N      (pReset_N),
    .cfg_start     (cfg_start),
    .cfg_len       (cfg_len),
    .cfg_abort     (cfg_abort),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .IO_ISOL_N     (IO_ISOL_N),
`ifdef CCFF_READBACK_CRC_EN
    .tail_crc      (tail_crc),
`endif
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 prog_clk = ~prog_clk;

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic exp_bit(input int i);
    logic [31:0] w;
    w = words[i / 32];
    return w[31 - (i % 32)];
  endfunction

  function automatic int bit_errors(input int len);
    int bad = 0;
    for (int i = 0; i < len; i++) if (got_bits[i] !== exp_bit(i)) bad++;
    return bad;
  endfunction

  // Starts a load, feeds words (valid rises on cycles where cyc%period==period-1
  // and holds until accepted) and records what the chain side sees.
  task automatic drive_load(input int len, input int nw, input int period,
                            input int abort_at, input int budget);
    int   widx;
    bit   acc;
    logic prev_head;
    n_en = 0; accepted = 0; extra_ready = 0;
    first_acc = -1; first_en = -1; last_en = -1; isol_rise = -1;
    stall_seen = 0; head_hold_ok = 1; finished = 0;
    widx = 0; s_valid = 0;
    cfg_len = 20'(len); cfg_start = 1; tick; cfg_start = 0;
    prev_head = ccff_head;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (!s_valid && widx < nw && (cyc % period) == period - 1) begin
        s_valid = 1; s_data = words[widx];
      end
      acc = s_valid && s_ready;
      if (s_ready && widx >= nw) extra_ready++;
      tick;
      if (acc) begin
        accepted++; widx++; s_valid = 0;
        if (first_acc < 0) first_acc = cyc;
      end
      if (ccff_shift_en) begin
        if (n_en < 128) got_bits[n_en] = ccff_head;
        n_en++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else if (first_en >= 0) begin
        if (ccff_head !== prev_head) head_hold_ok = 0;
        if (n_en < len) stall_seen = 1;
      end
      prev_head = ccff_head;
      if (abort_at > 0 && n_en == abort_at) begin
        cfg_abort = 1; tick; cfg_abort = 0; s_valid = 0;
        finished = 1;
        break;
      end
      if (IO_ISOL_N) begin
        isol_rise = cyc; finished = 1;
        break;
      end
    end
    s_valid = 0;
  endtask

  task automatic test_reset;
    pReset_N = 0; cfg_start = 0; cfg_len = '0; cfg_abort = 0;
    s_data = '0; s_valid = 0; ccff_tail = 0;
    tick; tick;
    checks++; if ({s_ready, ccff_head, ccff_shift_en} !== 3'b000) begin errors++;
      $display("FAIL reset_stream got %b want 000", {s_ready, ccff_head, ccff_shift_en}); end
    checks++; if (IO_ISOL_N !== 1'b0) begin errors++;
      $display("FAIL reset_isol got %b want 0", IO_ISOL_N); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++;
      $display("FAIL reset_status got %b want 000", {busy, done, err}); end
`ifdef CCFF_READBACK_CRC_EN
    checks++; if (tail_crc !== 16'hFFFF) begin errors++;
      $display("FAIL reset_crc got %h want ffff", tail_crc); end
`endif
    pReset_N = 1; tick;
    checks++; if ({busy, s_ready, IO_ISOL_N} !== 3'b000) begin errors++;
      $display("FAIL idle_after_reset got %b want 000", {busy, s_ready, IO_ISOL_N}); end
  endtask

  task automatic test_back_to_back;
    words[0] = 32'hA5A5A5A5; words[1] = 32'h0F0F0F0F;
    drive_load(64, 2, 1, 0, 200);
    checks++; if (finished !== 1'b1) begin errors++;
      $display("FAIL b2b_timeout got %b want 1", finished); end
    checks++; if (n_en !== 64) begin errors++;
      $display("FAIL b2b_count got %0d want 64", n_en); end
    checks++; if (last_en - first_en + 1 !== 64) begin errors++;
      $display("FAIL b2b_consecutive got span %0d want 64", last_en - first_en + 1); end
    checks++; if (bit_errors(64) !== 0) begin errors++;
      $display("FAIL b2b_bits got %0d wrong bits want 0", bit_errors(64)); end
    checks++; if (first_en - first_acc !== 1) begin errors++;
      $display("FAIL b2b_latency got %0d want 1", first_en - first_acc); end
    checks++; if (isol_rise - last_en !== 8) begin errors++;
      $display("FAIL b2b_isol_hold got %0d want 8", isol_rise - last_en); end
    checks++; if ({busy, done, err} !== 3'b010) begin errors++;
      $display("FAIL b2b_status got %b want 010", {busy, done, err}); end
  endtask

  task automatic test_partial_word;
    words[0] = 32'hFFFFFFFF; words[1] = 32'h80000000;
    drive_load(40, 2, 1, 0, 200);
    checks++; if (n_en !== 40) begin errors++;
      $display("FAIL partial_count got %0d want 40", n_en); end
    checks++; if (bit_errors(40) !== 0) begin errors++;
      $display("FAIL partial_bits got %0d wrong bits want 0", bit_errors(40)); end
    checks++; if (accepted !== 2) begin errors++;
      $display("FAIL partial_accepted got %0d want 2", accepted); end
    checks++; if (extra_ready !== 0) begin errors++;
      $display("FAIL partial_third_ready got %0d cycles want 0", extra_ready); end
    checks++; if ({done, IO_ISOL_N} !== 2'b11) begin errors++;
      $display("FAIL partial_done got %b want 11", {done, IO_ISOL_N}); end
  endtask

  task automatic test_starvation;
    words[0] = 32'h3C96E1F0;
    drive_load(32, 1, 5, 0, 200);
    checks++; if (first_en - first_acc !== 1 || first_acc !== 4) begin errors++;
      $display("FAIL slow_first got acc %0d en %0d want 4 5", first_acc, first_en); end
    checks++; if (n_en !== 32 || bit_errors(32) !== 0) begin errors++;
      $display("FAIL slow_bits got %0d enables want 32 with matching data", n_en); end
    words[0] = 32'hDEADBEEF; words[1] = 32'h13579BDF;
    drive_load(64, 2, 45, 0, 300);
    checks++; if (stall_seen !== 1'b1) begin errors++;
      $display("FAIL starve_enable_drop got %b want 1", stall_seen); end
    checks++; if (head_hold_ok !== 1'b1) begin errors++;
      $display("FAIL starve_head_hold got %b want 1", head_hold_ok); end
    checks++; if (n_en !== 64) begin errors++;
      $display("FAIL starve_count got %0d want 64", n_en); end
    checks++; if (bit_errors(64) !== 0) begin errors++;
      $display("FAIL starve_bits got %0d wrong bits want 0", bit_errors(64)); end
  endtask

  task automatic test_abort;
    words[0] = 32'hAAAAAAAA; words[1] = 32'h55555555;
    words[2] = 32'hAAAAAAAA; words[3] = 32'h55555555;
    drive_load(100, 4, 1, 10, 200);
    checks++; if (n_en !== 10) begin errors++;
      $display("FAIL abort_bits_before got %0d want 10", n_en); end
    checks++; if ({busy, err, done, IO_ISOL_N, ccff_shift_en, s_ready} !== 6'b010000) begin errors++;
      $display("FAIL abort_state got %b want 010000",
               {busy, err, done, IO_ISOL_N, ccff_shift_en, s_ready}); end
    tick;
    checks++; if ({busy, ccff_shift_en} !== 2'b00) begin errors++;
      $display("FAIL abort_quiet got %b want 00", {busy, ccff_shift_en}); end
    words[0] = 32'hC3000000;
    drive_load(8, 1, 1, 0, 100);
    checks++; if (n_en !== 8 || bit_errors(8) !== 0) begin errors++;
      $display("FAIL reload_bits got %0d enables want 8 with matching data", n_en); end
    checks++; if ({err, done, IO_ISOL_N} !== 3'b011) begin errors++;
      $display("FAIL reload_status got %b want 011", {err, done, IO_ISOL_N}); end
    checks++; if (isol_rise - last_en !== 8) begin errors++;
      $display("FAIL reload_isol_hold got %0d want 8", isol_rise - last_en); end
  endtask

  task automatic test_zero_len;
    int bad = 0;
    cfg_len = '0; cfg_start = 1; tick; cfg_start = 0;
    checks++; if ({err, busy, s_ready} !== 3'b100) begin errors++;
      $display("FAIL zero_len got %b want 100", {err, busy, s_ready}); end
    for (int i = 0; i < 4; i++) begin
      tick;
      if (busy !== 1'b0 || s_ready !== 1'b0 || err !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL zero_len_stays got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_shift;
    cfg_len = 20'd64; cfg_start = 1; tick; cfg_start = 0;
    s_valid = 1; s_data = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) tick;
    s_valid = 0;
    checks++; if ({busy, ccff_shift_en, ccff_head} !== 3'b111) begin errors++;
      $display("FAIL pre_reset_shifting got %b want 111", {busy, ccff_shift_en, ccff_head}); end
    pReset_N = 0; tick;
    checks++; if ({s_ready, ccff_head, ccff_shift_en, IO_ISOL_N, busy, done, err} !== 7'b0) begin errors++;
      $display("FAIL mid_reset got %b want 0000000",
               {s_ready, ccff_head, ccff_shift_en, IO_ISOL_N, busy, done, err}); end
`ifdef CCFF_READBACK_CRC_EN
    checks++; if (tail_crc !== 16'hFFFF) begin errors++;
      $display("FAIL mid_reset_crc got %h want ffff", tail_crc); end
`endif
    pReset_N = 1; tick;
`ifdef CCFF_READBACK_CRC_EN
    ccff_tail = 0; words[0] = 32'h12345678;
    drive_load(16, 1, 1, 0, 100);
    checks++; if (tail_crc !== 16'h1D0F) begin errors++;
      $display("FAIL crc_zero_tail got %h want 1d0f", tail_crc); end
`endif
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_partial_word;
    test_starvation;
    test_abort;
    test_zero_len;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
